// File: rtl/e203_exu_wbck_arb.sv
// Write-back arbiter: merges ALU results with FIFO-buffered long-pipe returns into one
// registered register-file write port, and exports a pending-destination bitmap.
module e203_exu_wbck_arb #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RFIDX_W   = 5,
    parameter int unsigned RFREG_NUM = 32,
    parameter int unsigned LP_DEPTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_wbck_i_valid,
    output logic                          alu_wbck_i_ready,
    input  logic [RFIDX_W-1:0]            alu_wbck_i_idx,
    input  logic [XLEN-1:0]               alu_wbck_i_wdat,
    input  logic                          longp_wbck_i_valid,
    output logic                          longp_wbck_i_ready,
    input  logic [RFIDX_W-1:0]            longp_wbck_i_idx,
    input  logic [XLEN-1:0]               longp_wbck_i_wdat,
    output logic                          wbck_dest_wen1,
    output logic [RFIDX_W-1:0]            wbck_dest_idx1,
    output logic [XLEN-1:0]               wbck_dest_dat1,
    output logic [RFREG_NUM-1:0]          longp_pend_vec,
    output logic [$clog2(LP_DEPTH):0]     longp_cnt
);

    localparam int unsigned PTR_W = $clog2(LP_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [RFIDX_W-1:0] lp_idx_q [LP_DEPTH];
    logic [RFIDX_W-1:0] lp_idx_d [LP_DEPTH];
    logic [XLEN-1:0]    lp_dat_q [LP_DEPTH];
    logic [XLEN-1:0]    lp_dat_d [LP_DEPTH];
    logic [LP_DEPTH-1:0] lp_vld_q, lp_vld_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               wen1_q, wen1_d;
    logic [RFIDX_W-1:0] idx1_q, idx1_d;
    logic [XLEN-1:0]    dat1_q, dat1_d;

    logic               full, empty, push, pop, alu_fire;
    logic [RFIDX_W-1:0] sel_idx;
    logic [XLEN-1:0]    sel_dat;

    always_comb begin
        empty    = (cnt_q == '0);
        full     = (cnt_q == CNT_W'(LP_DEPTH));
        push     = longp_wbck_i_valid & ~full;
        // Long-pipe has strict priority: any FIFO entry stalls the ALU.
        pop      = ~empty;
        alu_fire = alu_wbck_i_valid & empty;
    end

    always_comb begin
        lp_idx_d = lp_idx_q;
        lp_dat_d = lp_dat_q;
        lp_vld_d = lp_vld_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        if (pop) begin
            lp_vld_d[rptr_q] = 1'b0;
            rptr_d           = rptr_q + 1'b1;
        end
        if (push) begin
            lp_vld_d[wptr_q] = 1'b1;
            lp_idx_d[wptr_q] = longp_wbck_i_idx;
            lp_dat_d[wptr_q] = longp_wbck_i_wdat;
            wptr_d           = wptr_q + 1'b1;
        end
    end

    always_comb begin
        sel_idx = pop ? lp_idx_q[rptr_q] : alu_wbck_i_idx;
        sel_dat = pop ? lp_dat_q[rptr_q] : alu_wbck_i_wdat;
        wen1_d  = 1'b0;
        idx1_d  = idx1_q;
        dat1_d  = dat1_q;
        if (pop | alu_fire) begin
            wen1_d = (sel_idx != '0);
            idx1_d = sel_idx;
            dat1_d = sel_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LP_DEPTH; i++) begin
                lp_idx_q[i] <= '0;
                lp_dat_q[i] <= '0;
            end
            lp_vld_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            wen1_q   <= 1'b0;
            idx1_q   <= '0;
            dat1_q   <= '0;
        end else begin
            lp_idx_q <= lp_idx_d;
            lp_dat_q <= lp_dat_d;
            lp_vld_q <= lp_vld_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            wen1_q   <= wen1_d;
            idx1_q   <= idx1_d;
            dat1_q   <= dat1_d;
        end
    end

    always_comb begin
        longp_pend_vec = '0;
        for (int unsigned i = 0; i < LP_DEPTH; i++) begin
            if (lp_vld_q[i]) begin
                longp_pend_vec[lp_idx_q[i]] = 1'b1;
            end
        end
        longp_pend_vec[0] = 1'b0;
    end

    assign alu_wbck_i_ready   = empty;
    assign longp_wbck_i_ready = ~full;
    assign longp_cnt          = cnt_q;
    assign wbck_dest_wen1     = wen1_q;
    assign wbck_dest_idx1     = idx1_q;
    assign wbck_dest_dat1     = dat1_q;

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Scoreboard bench for the write-back arbiter: a queue-based FIFO model predicts handshakes,
// and expected register-file writes are queued with their due cycle.
module tb_e203_exu_wbck_arb;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned RFIDX_W  = 5;
    localparam int unsigned RFREG_N  = 32;
    localparam int unsigned LP_DEPTH = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               alu_valid = 1'b0, alu_ready;
    logic [RFIDX_W-1:0] alu_idx = '0;
    logic [XLEN-1:0]    alu_dat = '0;
    logic               lp_valid = 1'b0, lp_ready;
    logic [RFIDX_W-1:0] lp_idx = '0;
    logic [XLEN-1:0]    lp_dat = '0;
    logic               wen1;
    logic [RFIDX_W-1:0] idx1;
    logic [XLEN-1:0]    dat1;
    logic [RFREG_N-1:0] pend_vec;
    logic [$clog2(LP_DEPTH):0] cnt;

    e203_exu_wbck_arb #(
        .XLEN      (XLEN),
        .RFIDX_W   (RFIDX_W),
        .RFREG_NUM (RFREG_N),
        .LP_DEPTH  (LP_DEPTH)
    ) u_dut (
        .clk                (clk),
        .rst                (rst),
        .alu_wbck_i_valid   (alu_valid),
        .alu_wbck_i_ready   (alu_ready),
        .alu_wbck_i_idx     (alu_idx),
        .alu_wbck_i_wdat    (alu_dat),
        .longp_wbck_i_valid (lp_valid),
        .longp_wbck_i_ready (lp_ready),
        .longp_wbck_i_idx   (lp_idx),
        .longp_wbck_i_wdat  (lp_dat),
        .wbck_dest_wen1     (wen1),
        .wbck_dest_idx1     (idx1),
        .wbck_dest_dat1     (dat1),
        .longp_pend_vec     (pend_vec),
        .longp_cnt          (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RFIDX_W-1:0] idx;
        logic [XLEN-1:0]    dat;
    } lp_t;

    typedef struct {
        logic               wen;
        logic [RFIDX_W-1:0] idx;
        logic [XLEN-1:0]    dat;
        int                 cyc;
    } exp_t;

    lp_t  m_fifo [$];
    exp_t exp_q [$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [RFIDX_W-1:0] last_idx = '0;
    logic [XLEN-1:0]    last_dat = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [RFREG_N-1:0] model_pend();
        logic [RFREG_N-1:0] v = '0;
        foreach (m_fifo[i]) if (m_fifo[i].idx != 0) v[m_fifo[i].idx] = 1'b1;
        return v;
    endfunction

    task automatic check_state();
        chk("alu_ready", alu_ready, m_fifo.size() == 0);
        chk("lp_ready", lp_ready, m_fifo.size() < LP_DEPTH);
        chk("longp_cnt", cnt, m_fifo.size());
        chk("pend_vec", pend_vec, model_pend());
    endtask

    // Called just after a falling edge; drives one cycle of stimulus and checks the result.
    task automatic step(input logic av, input logic [RFIDX_W-1:0] ai, input logic [XLEN-1:0] ad,
                        input logic lv, input logic [RFIDX_W-1:0] li, input logic [XLEN-1:0] ld,
                        output logic alu_fired);
        exp_t e;
        lp_t  h;
        logic do_pop, do_push;
        alu_valid = av; alu_idx = ai; alu_dat = ad;
        lp_valid  = lv; lp_idx  = li; lp_dat  = ld;
        #1;
        check_state();
        do_pop    = (m_fifo.size() != 0);
        alu_fired = av && (m_fifo.size() == 0);
        do_push   = lv && (m_fifo.size() < LP_DEPTH);
        if (do_pop) begin
            h = m_fifo.pop_front();
            e = '{wen: (h.idx != 0), idx: h.idx, dat: h.dat, cyc: cyc + 1};
            exp_q.push_back(e);
        end else if (alu_fired) begin
            e = '{wen: (ai != 0), idx: ai, dat: ad, cyc: cyc + 1};
            exp_q.push_back(e);
        end
        if (do_push) m_fifo.push_back('{idx: li, dat: ld});
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            chk("wen1", wen1, e.wen);
            chk("idx1", idx1, e.idx);
            chk("dat1", dat1, e.dat);
            last_idx = e.idx;
            last_dat = e.dat;
        end else begin
            chk("wen1_idle", wen1, 1'b0);
            chk("idx1_hold", idx1, last_idx);
            chk("dat1_hold", dat1, last_dat);
        end
    endtask

    task automatic idle(input int n);
        logic f;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, f);
    endtask

    initial begin
        logic f;
        logic alu_pending;
        #1;
        chk("rst_wen1", wen1, 1'b0);
        chk("rst_idx1", idx1, '0);
        chk("rst_dat1", dat1, '0);
        check_state();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single ALU write, then long-pipe write with two-cycle latency.
        step(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0, f);
        idle(2);
        step(1'b0, '0, '0, 1'b1, 5'd7, 32'hDEAD, f);
        chk("pend7_set", pend_vec[7], 1'b1);
        chk("cnt_one", cnt, 1);
        idle(3);

        // Simultaneous ALU and long-pipe with FIFO empty.
        step(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, f);
        chk("alu_taken", f, 1'b1);
        idle(3);

        // Back-to-back long-pipe pushes with ALU held valid until accepted.
        alu_pending = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(alu_pending, 5'd20, 32'h2020, 1'b1, RFIDX_W'(10 + i), XLEN'(32'hC000 + i), f);
            if (f) alu_pending = 1'b0;
        end
        for (int i = 0; i < 6 && alu_pending; i++) begin
            step(1'b1, 5'd20, 32'h2020, 1'b0, '0, '0, f);
            if (f) alu_pending = 1'b0;
        end
        chk("alu_drained", alu_pending, 1'b0);
        idle(2);

        // x0 destinations on both sources.
        step(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, f);
        chk("x0_pend", pend_vec, '0);
        idle(3);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), RFIDX_W'($urandom), $urandom,
                 1'($urandom_range(0, 2) == 0), RFIDX_W'($urandom), $urandom, f);
        end
        idle(3);

        // Asynchronous reset with a FIFO entry and an output write pending.
        step(1'b1, 5'd6, 32'h6666, 1'b1, 5'd9, 32'h9999, f);
        alu_valid = 1'b0;
        lp_valid  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_wen1", wen1, 1'b0);
        chk("arst_cnt", cnt, 0);
        chk("arst_pend", pend_vec, '0);
        chk("arst_idx1", idx1, '0);
        m_fifo.delete();
        exp_q.delete();
        last_idx = '0;
        last_dat = '0;
        @(negedge clk);
        rst = 1'b0;
        idle(4);
        chk("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
